// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, h/v counters, coordinate decode,
// and sync/data-enable outputs delayed to line up with the downstream RGB path.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic       i_clk,
  input  logic       i_n_rst,
  output logic       o_pixelTick,
  output logic [9:0] o_n_PixelPos_X,
  output logic [9:0] o_n_PixelPos_Y,
  output logic       o_active,
  output logic       o_lineStart,
  output logic       o_frameStart,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_cnt;
  logic [9:0] h_cnt, v_cnt;
  logic       tick, h_wrap, active;
  logic       hs_lvl, vs_lvl;
  logic [2:0] raw_bus;

  // Tick is gated by reset so a reset landing on the tick cycle suppresses it.
  assign tick   = i_n_rst && (div_cnt == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst)                div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 4'd1;
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_lvl = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs_lvl = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign raw_bus = {hs_lvl, vs_lvl, active};

  assign o_pixelTick    = tick;
  assign o_active       = active;
  assign o_n_PixelPos_X = active ? h_cnt : '0;
  assign o_n_PixelPos_Y = active ? v_cnt : '0;
  assign o_lineStart    = tick && (h_cnt == '0);
  assign o_frameStart   = tick && (h_cnt == '0) && (v_cnt == '0);

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign {o_hsync, o_vsync, o_de} = raw_bus;
    end else begin : g_dly
      localparam logic [2:0] DLY_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};
      logic [PIPE_DELAY-1:0][2:0] sync_pipe;

      // Shifts once per pixel period so the delay is counted in pixels.
      always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) sync_pipe[i] <= DLY_RST;
        end else if (tick) begin
          sync_pipe[0] <= raw_bus;
          for (int i = 1; i < PIPE_DELAY; i++) sync_pipe[i] <= sync_pipe[i-1];
        end
      end

      assign {o_hsync, o_vsync, o_de} = sync_pipe[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 VGA display path. Divides the system clock to the pixel rate and runs horizontal and vertical counters. Drives the current pixel coordinate into the pixel/colour stage (the `i_n_PixelPos_X`/`i_n_PixelPos_Y` inputs of the monitor colour mapper). Produces hsync, vsync and data-enable, each delayed by a configurable number of pixel periods so they line up with the RGB output of the downstream stages.

## Interface

**Parameters**

- `CLK_DIV`, default 2: i_clk cycles per pixel period. Legal range is 1..16.
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing, in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing, in lines.
- `SYNC_POL`, default 0: asserted level of hsync/vsync (0 = active-low).
- `PIPE_DELAY`, default 1: pixel periods of delay applied to hsync, vsync and de. Legal range is 0..4.

**Ports**

- `i_clk`, input, 1: system clock. This is the only clock.
- `i_n_rst`, input, 1: asynchronous, active-low reset.
- `o_pixelTick`, output, 1: one-i_clk-cycle strobe marking the last cycle of each pixel period.
- `o_n_PixelPos_X`, output, 10: current pixel column. Value is h_cnt when active, otherwise 0.
- `o_n_PixelPos_Y`, output, 10: current pixel row. Value is v_cnt when active, otherwise 0.
- `o_active`, output, 1: current coordinate is inside the visible area. Undelayed.
- `o_lineStart`, output, 1: single-cycle pulse, asserted when tick is high and h_cnt==0.
- `o_frameStart`, output, 1: single-cycle pulse, asserted when tick is high, h_cnt==0 and v_cnt==0.
- `o_hsync`, `o_vsync`, output, 1 each: sync signals, delayed by PIPE_DELAY.
- `o_de`, output, 1: o_active delayed by PIPE_DELAY.

## Operation

**Totals**

- H_TOTAL = sum of the H_* parameters = 800.
- V_TOTAL = sum of the V_* parameters = 525.

**Pixel divider**

- div_cnt counts 0..CLK_DIV-1 and wraps.
- o_pixelTick = (div_cnt == CLK_DIV-1).
- With CLK_DIV=1, o_pixelTick is constantly 1 after reset.

**Counters**

- h_cnt and v_cnt are registered and change only on cycles where the tick is high.
- h_cnt increments each tick; at H_TOTAL-1 it wraps to 0.
- v_cnt increments only when h_cnt wraps; at V_TOTAL-1 it wraps to 0, simultaneous with the h_cnt wrap.
- No counter ever reaches H_TOTAL or V_TOTAL.

**Coordinate outputs**

- The coordinate (h_cnt, v_cnt) is presented for the whole pixel period. The tick marks the period's final cycle, and the new coordinate appears on the next cycle.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- X, Y and active are combinational decodes of registered counters. There are no registers beyond the counters on this path.

**Sync decode (undelayed)**

- h_sync_raw is asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. columns 656..751.
- v_sync_raw is asserted for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491. The whole line is asserted, including blanking.
- Output level is SYNC_POL when asserted and ~SYNC_POL when deasserted.

**Delay line**

- {hsync, vsync, de} pass through a PIPE_DELAY-deep shift register that shifts only on tick.
- With PIPE_DELAY=0 the raw decode drives the outputs directly.

**Arithmetic**

- Counters are 10 bits wide.
- All comparison bounds are computed from the parameters at elaboration time. There are no hard-coded 640/480 values.

## Timing

**Reset values (asynchronous, taking effect immediately on i_n_rst low)**

- div_cnt, h_cnt, v_cnt = 0.
- o_pixelTick = 0, except with CLK_DIV=1, where it is 1 as soon as reset releases.
- X = Y = 0, o_active = 1 (decode of 0,0).
- o_lineStart and o_frameStart follow the tick, so they are 0 in reset.
- Every delay-line stage resets to: hsync/vsync = ~SYNC_POL, de = 0.

**After reset release**

- The first tick occurs at i_clk cycle CLK_DIV-1, counted from the first rising edge after release.
- o_frameStart and o_lineStart pulse on that first tick.

**Frame period**

- H_TOTAL × V_TOTAL × CLK_DIV = 840000 i_clk cycles at default parameters.
- o_frameStart pulses exactly once per frame period.

**Delay alignment**

- For PIPE_DELAY=N, the value of o_de equals the o_active value from N pixel periods earlier. The same holds for o_hsync and o_vsync against their raw decodes.

**Reset mid-frame**

- Reset asserted mid-frame forces every output back to its reset value at once.
- There is no partial-line completion.
- Reset asserted during the tick cycle suppresses that tick.

## Test plan

- **Reset values:** hold i_n_rst=0 for 5 cycles. Required: X=Y=0, o_active=1, o_de=0, o_hsync=o_vsync=1, tick=0. After release, the first tick and o_frameStart occur at cycle 1 (CLK_DIV=2).
- **Line wrap:** run to h_cnt=799, v_cnt=10. On the next tick, X wraps to 0, Y becomes 11 and o_lineStart pulses. Check that o_active is 0 at X=640..799 and 1 at X=0..639.
- **Horizontal sync (PIPE_DELAY=0):** o_hsync falls at h_cnt=656 and rises at h_cnt=752. Low width is exactly 96 ticks = 192 i_clk cycles.
- **Vertical sync and frame period:** o_vsync is low for lines 490..491 only. Consecutive o_frameStart pulses are 840000 i_clk cycles apart, and v_cnt returns 524→0.
- **Delay alignment:** with PIPE_DELAY=2, CLK_DIV=1, the rising edge of o_de lags the rising edge of o_active at (0,0) by exactly 2 cycles. o_hsync falls 2 cycles after h_cnt reaches 656.
- **Mid-frame reset:** pulse i_n_rst low for 3 cycles at h_cnt=300, v_cnt=200 with CLK_DIV=2. All outputs return to reset values asynchronously, and counting restarts from (0,0) with o_frameStart on the first tick.
